// File: rtl/frame_reader_pkg.sv
// -----------------------------------------------------------------------------
// frame_reader_pkg
// Shared types and helpers for the acoustics frame reader:
//   state_t            FSM state encoding
//   SYNC_BYTE_DEFAULT  frame header byte
//   MAX_FRAME_LEN      largest frame the 8-bit, stride-4 ring buffer can supply
//   SAMPLE_W           ring buffer sample width
//   sample_byte()      splits a 10-bit sample into its hi/lo transmit bytes
//   store_addr_w()     address width of the local frame store
// -----------------------------------------------------------------------------
package frame_reader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    DRAIN,
    TX_HDR,
    TX_SEQ,
    TX_HI,
    TX_LO,
    TX_SUM
  } state_t;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
  localparam int         MAX_FRAME_LEN     = 64;
  localparam int         SAMPLE_W          = 10;

  // hi byte carries the two MSBs right-aligned, lo byte the eight LSBs
  function automatic logic [7:0] sample_byte(input logic [SAMPLE_W-1:0] sample,
                                             input logic                hi);
    return hi ? {6'b0, sample[9:8]} : sample[7:0];
  endfunction

  // at least one address bit, even for a single-entry store
  function automatic int store_addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/frame_capture_store.sv
// -----------------------------------------------------------------------------
// frame_capture_store
// Local frame store: FRAME_LEN x 10-bit register file, one synchronous write
// port and one asynchronous read port, so it can map to distributed RAM.
// Ports:
//   clk      clock
//   wr_en    write strobe, samples wr_data into entry wr_idx at posedge
//   wr_idx   write index
//   wr_data  sample to store
//   rd_idx   read index
//   rd_data  entry rd_idx, combinational
// The array is sized to a power of two so any index value stays in range;
// entries at or above FRAME_LEN are never written or used.
// -----------------------------------------------------------------------------
module frame_capture_store
  import frame_reader_pkg::*;
#(
  parameter int FRAME_LEN = 64,
  parameter int AW        = store_addr_w(FRAME_LEN)
) (
  input  logic                clk,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_idx,
  input  logic [SAMPLE_W-1:0] wr_data,
  input  logic [AW-1:0]       rd_idx,
  output logic [SAMPLE_W-1:0] rd_data
);

  logic [SAMPLE_W-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/frame_reader.sv
// -----------------------------------------------------------------------------
// frame_reader
// Consumer end of the acoustics ring buffer. A primed trigger requests one
// frame (send_frame high for FRAME_LEN cycles), captures the returned samples
// into a local store, then sends header, sequence, hi/lo bytes per sample and
// a modulo-256 checksum over a valid/ready byte stream.
// Ports:
//   clk            clock
//   reset_b        asynchronous active-low reset
//   trigger        single-cycle frame request pulse
//   buf_primed     ring buffer primed level; latched into a sticky flag
//   send_frame     registered request to the ring buffer
//   frame_data     ring buffer read data, one sample per cycle
//   tx_data        byte toward the host link
//   tx_valid       tx_data valid
//   tx_ready       host link accepts a byte when tx_valid && tx_ready
//   busy           high in every state except IDLE
//   frame_dropped  one-cycle pulse when a trigger is rejected
//   frame_seq      sequence number of the last completed frame
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for a trigger with the ring buffer primed
// REQ    | send_frame high, FRAME_LEN cycles timed by a down-counter
// DRAIN  | request done, waiting for the last sample to land in the store
// TX_HDR | sending SYNC_BYTE
// TX_SEQ | sending frame_seq+1
// TX_HI  | sending upper 2 bits of sample tx_idx
// TX_LO  | sending lower 8 bits of sample tx_idx
// TX_SUM | sending checksum; frame_seq advances on its handshake
// -----------------------------------------------------------------------------
module frame_reader
  import frame_reader_pkg::*;
#(
  parameter int         FRAME_LEN  = 64,
  parameter int         RD_LATENCY = 1,
  parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEFAULT
) (
  input  logic                clk,
  input  logic                reset_b,
  input  logic                trigger,
  input  logic                buf_primed,
  output logic                send_frame,
  input  logic [SAMPLE_W-1:0] frame_data,
  output logic [7:0]          tx_data,
  output logic                tx_valid,
  input  logic                tx_ready,
  output logic                busy,
  output logic                frame_dropped,
  output logic [7:0]          frame_seq
);

  localparam int IDX_W = $clog2(FRAME_LEN + 1);
  localparam int AW    = store_addr_w(FRAME_LEN);

  localparam logic [IDX_W-1:0] ONE      = IDX_W'(1);
  localparam logic [IDX_W-1:0] LEN_IDX  = IDX_W'(FRAME_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  if (FRAME_LEN < 1 || FRAME_LEN > MAX_FRAME_LEN) begin : g_bad_frame_len
    $error("frame_reader: FRAME_LEN out of range");
  end
  if (RD_LATENCY < 1 || RD_LATENCY > 2) begin : g_bad_rd_latency
    $error("frame_reader: RD_LATENCY out of range");
  end

  state_t              state;
  logic                primed_seen;
  logic [IDX_W-1:0]    req_cnt;
  logic [IDX_W-1:0]    cap_cnt;
  logic [IDX_W-1:0]    tx_idx;
  logic [IDX_W-1:0]    tx_idx_inc;
  logic [RD_LATENCY:0] sf_pipe;
  logic [7:0]          checksum;

  logic                accept;
  logic                handshake;
  logic                cap_wr_en;
  logic                cap_last;
  logic [AW-1:0]       store_rd_idx;
  logic [SAMPLE_W-1:0] store_rd_data;

  assign accept     = (state == IDLE) && trigger && primed_seen;
  assign handshake  = tx_valid && tx_ready;
  assign tx_idx_inc = tx_idx + ONE;

  // Sample k is on frame_data RD_LATENCY+1 cycles after the ring buffer saw
  // request cycle k, so a delayed copy of send_frame marks the capture window.
  assign cap_wr_en = sf_pipe[RD_LATENCY] && (cap_cnt != LEN_IDX);
  assign cap_last  = cap_wr_en && (cap_cnt == LAST_IDX);

  // In TX_LO the next byte is the hi half of the following sample, so look ahead.
  assign store_rd_idx = (state == TX_LO) ? tx_idx_inc[AW-1:0] : tx_idx[AW-1:0];

  frame_capture_store #(
    .FRAME_LEN (FRAME_LEN),
    .AW        (AW)
  ) u_store (
    .clk     (clk),
    .wr_en   (cap_wr_en),
    .wr_idx  (cap_cnt[AW-1:0]),
    .wr_data (frame_data),
    .rd_idx  (store_rd_idx),
    .rd_data (store_rd_data)
  );

  // Capture runs independently of the FSM; it overlaps REQ -> DRAIN.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      sf_pipe <= '0;
      cap_cnt <= '0;
    end else begin
      sf_pipe <= {sf_pipe[RD_LATENCY-1:0], send_frame};
      if (accept) begin
        cap_cnt <= '0;
      end else if (cap_wr_en) begin
        cap_cnt <= cap_cnt + ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state         <= IDLE;
      primed_seen   <= 1'b0;
      send_frame    <= 1'b0;
      tx_valid      <= 1'b0;
      tx_data       <= '0;
      busy          <= 1'b0;
      frame_dropped <= 1'b0;
      frame_seq     <= '0;
      req_cnt       <= '0;
      tx_idx        <= '0;
      checksum      <= '0;
    end else begin
      frame_dropped <= trigger && !accept;
      if (buf_primed) begin
        primed_seen <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (accept) begin
            state      <= REQ;
            send_frame <= 1'b1;
            busy       <= 1'b1;
            req_cnt    <= LAST_IDX;
          end
        end

        REQ: begin
          if (req_cnt == '0) begin
            send_frame <= 1'b0;
            state      <= DRAIN;
          end else begin
            req_cnt <= req_cnt - ONE;
          end
        end

        DRAIN: begin
          if (cap_last || (cap_cnt == LEN_IDX)) begin
            state    <= TX_HDR;
            tx_valid <= 1'b1;
            tx_data  <= SYNC_BYTE;
          end
        end

        TX_HDR: begin
          if (handshake) begin
            state    <= TX_SEQ;
            tx_data  <= frame_seq + 8'd1;
            checksum <= '0;
            tx_idx   <= '0;
          end
        end

        TX_SEQ: begin
          if (handshake) begin
            state    <= TX_HI;
            tx_data  <= sample_byte(store_rd_data, 1'b1);
            checksum <= checksum + tx_data;
          end
        end

        TX_HI: begin
          if (handshake) begin
            state    <= TX_LO;
            tx_data  <= sample_byte(store_rd_data, 1'b0);
            checksum <= checksum + tx_data;
          end
        end

        TX_LO: begin
          if (handshake) begin
            checksum <= checksum + tx_data;
            tx_idx   <= tx_idx_inc;
            if (tx_idx_inc != LEN_IDX) begin
              state   <= TX_HI;
              tx_data <= sample_byte(store_rd_data, 1'b1);
            end else begin
              state   <= TX_SUM;
              tx_data <= checksum + tx_data;
            end
          end
        end

        TX_SUM: begin
          if (handshake) begin
            state     <= IDLE;
            tx_valid  <= 1'b0;
            busy      <= 1'b0;
            frame_seq <= frame_seq + 8'd1;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_reader.sv
// -----------------------------------------------------------------------------
// tb_frame_reader
// Scoreboard bench: the stimulus pushes the expected byte stream of each frame
// into exp_q; a monitor pops and compares on every tx handshake and checks that
// tx_data/tx_valid hold during stalls. The ring buffer is modelled with
// RAM[a] = a*3, head = 8, one cycle of read latency.
// -----------------------------------------------------------------------------
module tb_frame_reader;

  localparam int FLEN = 4;

  logic       clk = 1'b0;
  logic       reset_b;
  logic       trigger;
  logic       buf_primed;
  logic       send_frame;
  logic [9:0] frame_data;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       frame_dropped;
  logic [7:0] frame_seq;

  frame_reader #(
    .FRAME_LEN  (FLEN),
    .RD_LATENCY (1),
    .SYNC_BYTE  (8'hA5)
  ) dut (
    .clk           (clk),
    .reset_b       (reset_b),
    .trigger       (trigger),
    .buf_primed    (buf_primed),
    .send_frame    (send_frame),
    .frame_data    (frame_data),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .busy          (busy),
    .frame_dropped (frame_dropped),
    .frame_seq     (frame_seq)
  );

  always #5 clk = ~clk;

  // ring buffer model: address registered on each request cycle, data one
  // cycle later
  logic [7:0] head = 8'd8;
  logic [7:0] rb_ptr = 8'd8;
  logic [7:0] rb_addr = 8'd0;

  function automatic logic [9:0] ram_val(input logic [7:0] a);
    return 10'(a * 3);
  endfunction

  always @(posedge clk) begin
    if (send_frame) begin
      rb_addr <= rb_ptr;
      rb_ptr  <= rb_ptr + 8'd4;
    end else begin
      rb_ptr <= head;
    end
    frame_data <= ram_val(rb_addr);
  end

  // hand-computed stream of the first frame: A5, seq 01, samples 24,36,48,60
  logic [7:0] frame1_vec [11] = '{8'hA5, 8'h01, 8'h00, 8'h18, 8'h00, 8'h24,
                                   8'h00, 8'h30, 8'h00, 8'h3C, 8'hA9};

  logic [7:0] exp_q[$];
  int n_checks = 0;
  int n_errs   = 0;
  int n_popped = 0;
  int sf_cnt   = 0;
  int drop_cnt = 0;
  int stall_cnt = 0;
  int ready_mode = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_model_frame(input logic [7:0] seq);
    logic [7:0] sum;
    logic [9:0] v;
    exp_q.push_back(8'hA5);
    exp_q.push_back(seq);
    sum = seq;
    for (int k = 0; k < FLEN; k++) begin
      v = ram_val(8'(8 + 4 * k));
      exp_q.push_back({6'b0, v[9:8]});
      exp_q.push_back(v[7:0]);
      sum = sum + {6'b0, v[9:8]} + v[7:0];
    end
    exp_q.push_back(sum);
  endtask

  task automatic monitor();
    logic       stall_prev = 1'b0;
    logic [7:0] prev_data  = 8'h00;
    logic [7:0] exp_b;
    forever begin
      @(negedge clk);
      if (!reset_b) begin
        exp_q.delete();
        stall_prev = 1'b0;
      end else begin
        if (send_frame)    sf_cnt++;
        if (frame_dropped) drop_cnt++;
        if (stall_prev) begin
          check("stall_valid_held", 32'(tx_valid), 32'd1);
          check("stall_data_held", 32'(tx_data), 32'(prev_data));
        end
        if (tx_valid && tx_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_byte", 32'(tx_data), 32'h100);
          end else begin
            exp_b = exp_q.pop_front();
            check("tx_byte", 32'(tx_data), 32'(exp_b));
          end
          n_popped++;
        end
        stall_prev = tx_valid && !tx_ready;
        prev_data  = tx_data;
        if (stall_prev) stall_cnt++;
      end
    end
  endtask

  task automatic drive_ready();
    int cyc = 0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      tx_ready = (ready_mode == 0) || (cyc % 3 == 0);
    end
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_trigger();
    trigger = 1'b1;
    @(posedge clk);
    #1;
    trigger = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    logic done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(posedge clk);
      #1;
      if (!busy) done = 1'b1;
    end
    check(name, 32'(done), 32'd1);
  endtask

  task automatic wait_popped(input int target);
    logic done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      if (n_popped >= target) done = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    check("wait_bytes_timeout", 32'(done), 32'd1);
  endtask

  task automatic check_reset_outputs(input string name);
    check(name, {send_frame, tx_valid, busy, frame_dropped, tx_data, frame_seq}, 32'd0);
  endtask

  task automatic run_stimulus();
    int base;
    int sf_base;
    int drop_base;
    int stall_base;

    reset_b    = 1'b0;
    trigger    = 1'b0;
    buf_primed = 1'b0;
    tx_ready   = 1'b1;
    cycles(3);
    check_reset_outputs("reset_values");
    reset_b = 1'b1;
    cycles(2);

    // trigger before the buffer is primed
    sf_base = sf_cnt;
    pulse_trigger();
    check("unprimed_dropped", 32'(frame_dropped), 32'd1);
    cycles(1);
    check("unprimed_drop_one_cycle", 32'(frame_dropped), 32'd0);
    cycles(3);
    check("unprimed_no_request", {busy, tx_valid, send_frame}, 32'd0);
    check("unprimed_no_send_cycles", 32'(sf_cnt - sf_base), 32'd0);

    buf_primed = 1'b1;
    cycles(2);

    // frame 1: full-rate, hand-computed stream
    for (int i = 0; i < 11; i++) exp_q.push_back(frame1_vec[i]);
    sf_base = sf_cnt;
    pulse_trigger();
    wait_idle("frame1_done");
    check("frame1_send_cycles", 32'(sf_cnt - sf_base), 32'd4);
    check("frame1_seq", 32'(frame_seq), 32'd1);
    check("frame1_queue_empty", 32'(exp_q.size()), 32'd0);

    // frame 2: tx_ready high one cycle in three
    ready_mode = 1;
    stall_base = stall_cnt;
    push_model_frame(8'h02);
    pulse_trigger();
    wait_idle("frame2_done");
    ready_mode = 0;
    check("frame2_stalls_seen", 32'(stall_cnt > stall_base), 32'd1);
    check("frame2_seq", 32'(frame_seq), 32'd2);
    check("frame2_queue_empty", 32'(exp_q.size()), 32'd0);

    // frame 3: second trigger while in TX_HI
    push_model_frame(8'h03);
    drop_base = drop_cnt;
    base = n_popped;
    pulse_trigger();
    wait_popped(base + 2);
    pulse_trigger();
    wait_idle("frame3_done");
    check("busy_trigger_dropped", 32'(drop_cnt - drop_base), 32'd1);
    check("frame3_seq", 32'(frame_seq), 32'd3);
    check("frame3_queue_empty", 32'(exp_q.size()), 32'd0);

    // frame 4: reset asserted during TX_LO of sample 0
    push_model_frame(8'h04);
    base = n_popped;
    pulse_trigger();
    wait_popped(base + 3);
    reset_b = 1'b0;
    #1;
    check_reset_outputs("midframe_reset_values");
    cycles(2);
    check_reset_outputs("reset_held_values");
    reset_b = 1'b1;
    cycles(2);
    check("reset_no_partial_bytes", 32'(tx_valid), 32'd0);

    // fresh frames after reset; seq wraps on the 256th
    for (int k = 1; k <= 256; k++) begin
      push_model_frame(8'(k));
      if (k == 10) begin
        drop_base = drop_cnt;
        base = n_popped;
        pulse_trigger();
        wait_popped(base + 10);
        pulse_trigger();
        wait_idle("sum_frame_done");
        cycles(2);
        check("sum_trigger_dropped", 32'(drop_cnt - drop_base), 32'd1);
        check("sum_trigger_no_frame", 32'(busy), 32'd0);
      end else begin
        pulse_trigger();
        wait_idle("loop_frame_done");
      end
      if (k == 1)   check("post_reset_seq", 32'(frame_seq), 32'd1);
      if (k == 255) check("seq_255", 32'(frame_seq), 32'd255);
      cycles(1);
    end
    check("seq_wrapped", 32'(frame_seq), 32'd0);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    fork
      run_stimulus();
      monitor();
      drive_ready();
    join_any
    disable fork;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_errs);
    $finish;
  end

endmodule
